// File: rtl/gate_tester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_tester: drives the four {a,b} vectors into a 2-input gate under test,
// samples its response s and compares it with the expected function op.
// Revision: 1.0
// ---------------------------------------------------------------------------
module gate_tester #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] op,
  output logic       a,
  output logic       b,
  input  logic       s,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] resp,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE - 1);

  state_t     state;
  logic [2:0] op_q;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic       expected;

  // Expected response for the vector currently driven on {a,b}.
  always_comb begin
    expected = 1'b0;
    case (op_q)
      3'b000:  expected = a & b;
      3'b001:  expected = a | b;
      3'b010:  expected = a ^ b;
      3'b011:  expected = ~(a & b);
      3'b100:  expected = ~(a | b);
      3'b101:  expected = ~(a ^ b);
      3'b110:  expected = ~a;
      default: expected = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= 3'b000;
      idx       <= 2'd0;
      cnt       <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      resp      <= 4'd0;
      err_count <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q      <= op;
            resp      <= 4'd0;
            err_count <= 3'd0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            a         <= 1'b0;
            b         <= 1'b0;
            idx       <= 2'd0;
            cnt       <= 4'd0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            resp[idx] <= s;
            if (s != expected) begin
              err_count <= err_count + 3'd1;
            end
            cnt <= 4'd0;
            if (idx != 2'd3) begin
              idx    <= idx + 2'd1;
              {a, b} <= idx + 2'd1;
            end else begin
              // done is registered here so it is high for the DONE cycle
              idx   <= 2'd0;
              a     <= 1'b0;
              b     <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        DONE: begin
          pass  <= (err_count == 3'd0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gate_tester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gate_tester: checks gate_tester (SETTLE=1 and SETTLE=2) against a
// truth-table reference model. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_gate_tester;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start1, start2;
  logic [2:0] op;
  logic [3:0] tt1, tt2;
  logic       sel;

  logic       a1, b1, s1, busy1, done1, pass1;
  logic [3:0] resp1;
  logic [2:0] err1;
  logic       a2, b2, s2, busy2, done2, pass2;
  logic [3:0] resp2;
  logic [2:0] err2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // The gate under test is modelled as a truth table indexed by {a,b}.
  assign s1 = tt1[{a1, b1}];
  assign s2 = tt2[{a2, b2}];

  gate_tester #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op), .a(a1), .b(b1), .s(s1),
    .busy(busy1), .done(done1), .pass(pass1), .resp(resp1), .err_count(err1)
  );

  gate_tester #(.SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op), .a(a2), .b(b2), .s(s2),
    .busy(busy2), .done(done2), .pass(pass2), .resp(resp2), .err_count(err2)
  );

  logic       a_m, b_m, busy_m, done_m, pass_m;
  logic [3:0] resp_m;
  logic [2:0] err_m;
  assign a_m    = sel ? a1    : a2;
  assign b_m    = sel ? b1    : b2;
  assign busy_m = sel ? busy1 : busy2;
  assign done_m = sel ? done1 : done2;
  assign pass_m = sel ? pass1 : pass2;
  assign resp_m = sel ? resp1 : resp2;
  assign err_m  = sel ? err1  : err2;

  function automatic logic [3:0] op_table(input logic [2:0] o);
    logic [3:0] t;
    logic x, y;
    t = 4'd0;
    for (int v = 0; v < 4; v++) begin
      x = (v >= 2);
      y = (v % 2 == 1);
      case (o)
        3'd0: t[v] = x && y;
        3'd1: t[v] = x || y;
        3'd2: t[v] = x != y;
        3'd3: t[v] = !(x && y);
        3'd4: t[v] = !(x || y);
        3'd5: t[v] = x == y;
        3'd6: t[v] = !x;
        default: t[v] = x;
      endcase
    end
    return t;
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".a"}, a_m, 0);
    chk({tag, ".b"}, b_m, 0);
    chk({tag, ".busy"}, busy_m, 0);
    chk({tag, ".done"}, done_m, 0);
    chk({tag, ".pass"}, pass_m, 0);
    chk({tag, ".resp"}, resp_m, 0);
    chk({tag, ".err"}, err_m, 0);
  endtask

  // One full sweep; every cycle from the start edge to two idle cycles after done.
  task automatic run_sweep(input logic use1, input logic [2:0] opv,
                           input logic [3:0] ttv, input logic disturb);
    int         settle;
    logic [3:0] exp_resp;
    int         exp_err;
    settle   = use1 ? 1 : 2;
    exp_resp = ttv;
    exp_err  = $countones(ttv ^ op_table(opv));
    sel = use1;
    if (use1) tt1 = ttv; else tt2 = ttv;
    op = opv;
    if (use1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start2 = 1'b0;
    for (int n = 0; n < 4 * settle; n++) begin
      chk("run.busy", busy_m, 1);
      chk("run.done", done_m, 0);
      chk("run.ab", {a_m, b_m}, 8'(n / settle));
      if (disturb && n == 3) begin
        if (use1) start1 = 1'b1; else start2 = 1'b1;
        op = 3'b001;
      end
      if (disturb && n == 4) begin
        start1 = 1'b0;
        start2 = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("fin.done", done_m, 1);
    chk("fin.busy", busy_m, 0);
    chk("fin.ab", {a_m, b_m}, 0);
    @(posedge clk); #1;
    chk("post.done", done_m, 0);
    chk("post.busy", busy_m, 0);
    for (int h = 0; h < 3; h++) begin
      chk("hold.resp", resp_m, exp_resp);
      chk("hold.err", err_m, 8'(exp_err));
      chk("hold.pass", pass_m, (exp_err == 0) ? 1 : 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    op     = 3'd0;
    tt1    = 4'd0;
    tt2    = 4'd0;
    sel    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("rst2");
    sel = 1'b1;
    check_zero("rst1");
    rst_n = 1'b1;

    // Directed sweeps: AND ok, stuck-at-1, wrong gate, XOR at SETTLE=1.
    run_sweep(1'b0, 3'b000, 4'b1000, 1'b0);
    run_sweep(1'b0, 3'b000, 4'b1111, 1'b0);
    run_sweep(1'b0, 3'b000, 4'b1110, 1'b0);
    run_sweep(1'b1, 3'b010, 4'b0110, 1'b0);

    // Reset five cycles into a sweep aborts it with no done pulse.
    sel   = 1'b0;
    tt2   = 4'b1111;
    op    = 3'b000;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_zero("abort");
    for (int k = 0; k < 10; k++) begin
      chk("abort.nodone", done_m, 0);
      @(posedge clk); #1;
    end
    run_sweep(1'b0, 3'b000, 4'b1000, 1'b0);

    // Mid-sweep start and op change are ignored.
    run_sweep(1'b0, 3'b000, 4'b1110, 1'b1);

    // Randomized sweeps on both settle settings.
    for (int r = 0; r < 12; r++) begin
      run_sweep(r % 2 == 1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
